// File: rtl/amp_channel_select.sv
// Picks one slot per frame from the amplifier's time-multiplexed word stream and
// forwards it, optionally converted to two's complement, to the DAC pipeline.
module amp_channel_select #(
   parameter int unsigned NUM_SLOTS = 35,
   parameter bit          TWOS_COMP = 1'b1
) (
   input  logic        dataclk,
   input  logic        reset,
   input  logic        frame_start,
   input  logic        in_valid,
   input  logic [15:0] in_data,
   input  logic [5:0]  sel_channel,
   input  logic        dac_en,
   input  logic        clear_flags,
   output logic [15:0] ampl_to_DAC,
   output logic        sample_valid,
   output logic [5:0]  slot,
   output logic [15:0] frame_count,
   output logic        missed_sample,
   output logic        overrun
);

   localparam logic [5:0] LAST_SLOT = 6'(NUM_SLOTS - 1);

   typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DONE} state_t;

   state_t      state, state_nxt;
   logic [5:0]  sel_latched;
   logic        captured;
   logic        capture;
   logic        overrun_set;
   logic        missed_set;
   logic [15:0] conv_data;

   always_ff @(posedge dataclk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (frame_start) begin
         state_nxt = S_COLLECT;
      end else begin
         case (state)
            S_COLLECT: if (in_valid && slot == LAST_SLOT) state_nxt = S_DONE;
            default:   state_nxt = state;
         endcase
      end
   end

   // A word arriving with frame_start is slot 0 of the new frame, matched against the live sel_channel.
   always_comb begin
      capture     = 1'b0;
      overrun_set = 1'b0;
      missed_set  = 1'b0;
      conv_data   = TWOS_COMP ? {~in_data[15], in_data[14:0]} : in_data;
      if (frame_start) begin
         capture    = dac_en && in_valid && (sel_channel == 6'd0);
         missed_set = (state != S_IDLE) && !captured && dac_en;
      end else begin
         capture     = dac_en && in_valid && (state == S_COLLECT) && (slot == sel_latched);
         overrun_set = in_valid && (state == S_DONE);
      end
   end

   always_ff @(posedge dataclk or negedge reset) begin
      if (!reset) begin
         ampl_to_DAC   <= '0;
         sample_valid  <= 1'b0;
         slot          <= '0;
         frame_count   <= '0;
         missed_sample <= 1'b0;
         overrun       <= 1'b0;
         sel_latched   <= '0;
         captured      <= 1'b0;
      end else begin
         sample_valid <= capture;
         if (capture) ampl_to_DAC <= conv_data;

         if (frame_start) begin
            slot        <= in_valid ? 6'd1 : 6'd0;
            frame_count <= frame_count + 16'd1;
            sel_latched <= sel_channel;
         end else if (state == S_COLLECT && in_valid && slot != LAST_SLOT) begin
            slot <= slot + 6'd1;
         end

         if (capture)          captured <= 1'b1;
         else if (frame_start) captured <= 1'b0;

         if (missed_set)       missed_sample <= 1'b1;
         else if (clear_flags) missed_sample <= 1'b0;

         if (overrun_set)      overrun <= 1'b1;
         else if (clear_flags) overrun <= 1'b0;
      end
   end

endmodule
